// File: rtl/pad_bidir_ctrl.sv
// pad_bidir_ctrl: per-pin bidirectional pad sequencer with turnaround dead-time,
// two-flop input synchronisation, edge pulses and sticky drive-contention detection.
module pad_bidir_ctrl #(
   parameter int WIDTH       = 8,
   parameter int TURN_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] DIR_REQ,
   input  logic [WIDTH-1:0] DOUT,
   output logic [WIDTH-1:0] DIN,
   output logic [WIDTH-1:0] DIR_ACK,
   output logic [WIDTH-1:0] BUSY,
   output logic [WIDTH-1:0] RISE,
   output logic [WIDTH-1:0] FALL,
   output logic [WIDTH-1:0] CONFLICT,
   input  logic [WIDTH-1:0] CONFLICT_CLR,
   output logic [WIDTH-1:0] PAD_O,
   output logic [WIDTH-1:0] PAD_NOE,
   input  logic [WIDTH-1:0] PAD_I
);
   localparam logic [1:0] S_IN       = 2'd0;
   localparam logic [1:0] S_TURN_OUT = 2'd1;
   localparam logic [1:0] S_DRIVE    = 2'd2;
   localparam logic [1:0] S_TURN_IN  = 2'd3;
   localparam logic [3:0] LOAD       = 4'(TURN_CYCLES - 1);

   logic [WIDTH-1:0] sync1, din_prev, o_d1, o_d2;

   // o_d2 lines up the driven value with the 2-flop-delayed pad sample
   always_ff @(posedge CLK or posedge RESET)
      if (RESET) begin
         sync1    <= '0;
         DIN      <= '0;
         din_prev <= '0;
         o_d1     <= '0;
         o_d2     <= '0;
      end else begin
         sync1    <= PAD_I;
         DIN      <= sync1;
         din_prev <= DIN;
         o_d1     <= PAD_O;
         o_d2     <= o_d1;
      end

   for (genvar g = 0; g < WIDTH; g++) begin : g_pin
      logic [1:0] st, nst, settle;
      logic [3:0] cnt, ncnt;
      logic       live, mm, hit, hit_q, ack, busy, noe, o, rise, fall, conf;

      always_comb begin
         nst  = st;
         ncnt = cnt;
         case (st)
            S_IN:
               if (DIR_REQ[g]) begin
                  nst  = S_TURN_OUT;
                  ncnt = LOAD;
               end
            S_TURN_OUT:
               if (!DIR_REQ[g]) nst = S_IN;
               else if (cnt == 4'd0) nst = S_DRIVE;
               else ncnt = cnt - 4'd1;
            S_DRIVE:
               if (!DIR_REQ[g]) begin
                  nst  = S_TURN_IN;
                  ncnt = LOAD;
               end
            default:
               if (cnt != 4'd0) ncnt = cnt - 4'd1;
               else begin
                  nst  = DIR_REQ[g] ? S_TURN_OUT : S_IN;
                  ncnt = DIR_REQ[g] ? LOAD : cnt;
               end
         endcase
      end

      assign live = (st == S_IN) || (st == S_DRIVE);
      // unknown pad values count as disagreement
      assign mm   = (DIN[g] === o_d2[g]) ? 1'b0 : 1'b1;
      assign hit  = (st == S_DRIVE) && (settle == 2'd3) && mm;

      always_ff @(posedge CLK or posedge RESET)
         if (RESET) begin
            st     <= S_IN;
            cnt    <= '0;
            settle <= '0;
            hit_q  <= 1'b0;
            ack    <= 1'b0;
            busy   <= 1'b0;
            noe    <= 1'b1;
            o      <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            conf   <= 1'b0;
         end else begin
            st     <= nst;
            cnt    <= ncnt;
            ack    <= st == S_DRIVE;
            busy   <= (st == S_TURN_OUT) || (st == S_TURN_IN);
            noe    <= st != S_DRIVE;
            o      <= ((st == S_TURN_OUT) || (st == S_DRIVE)) ? DOUT[g] : o;
            settle <= (st == S_DRIVE) ? settle + {1'b0, settle != 2'd3} : 2'd0;
            hit_q  <= hit;
            rise   <= live & DIN[g] & ~din_prev[g];
            fall   <= live & ~DIN[g] & din_prev[g];
            conf   <= (hit & hit_q) | (conf & ~CONFLICT_CLR[g]);
         end

      assign DIR_ACK[g]  = ack;
      assign BUSY[g]     = busy;
      assign PAD_NOE[g]  = noe;
      assign PAD_O[g]    = o;
      assign RISE[g]     = rise;
      assign FALL[g]     = fall;
      assign CONFLICT[g] = conf;
   end
endmodule
